// File: rtl/tdm_demux_1to8.sv
// tdm_demux_1to8
// Recovers eight channels from a time-division-multiplexed serial stream.
// Beats are collected into a shadow register slot by slot. A complete frame
// is copied to dout in one step, so dout never shows a partial frame.
// Framing is tracked by a two-state machine: HUNT waits for frame_sync and
// RECV follows the slot counter. Sync violations give a one-cycle sync_err.

module tdm_demux_1to8 #(
    parameter int DATA_W = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     din,
    input  logic                  din_valid,
    input  logic                  frame_sync,
    output logic [8*DATA_W-1:0]   dout,
    output logic                  frame_valid,
    output logic [2:0]            sel,
    output logic                  locked,
    output logic                  sync_err
);

    typedef enum logic [0:0] {
        ST_HUNT = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    localparam int FRAME_W = 8 * DATA_W;

    state_t               state_q,       state_d;
    logic [2:0]           sel_q,         sel_d;
    logic [FRAME_W-1:0]   shadow_q,      shadow_d;
    logic [FRAME_W-1:0]   dout_q,        dout_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 sync_err_q,    sync_err_d;

    // Next-state, slot routing and frame publication for one accepted beat
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        shadow_d      = shadow_q;
        dout_d        = dout_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (din_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (frame_sync) begin
                        // Sync found: this beat is slot 0 of the first frame
                        shadow_d[DATA_W-1:0] = din;
                        sel_d                = 3'd1;
                        state_d              = ST_RECV;
                    end else begin
                        // Unsynchronised data is dropped silently
                        sel_d   = 3'd0;
                        state_d = ST_HUNT;
                    end
                end

                ST_RECV: begin
                    if (frame_sync) begin
                        // Sync anywhere other than slot 0 aborts the frame
                        // being collected but still starts a new one.
                        if (sel_q != 3'd0) begin
                            sync_err_d = 1'b1;
                        end else begin
                            sync_err_d = 1'b0;
                        end
                        shadow_d[DATA_W-1:0] = din;
                        sel_d                = 3'd1;
                    end else if (sel_q == 3'd0) begin
                        // Slot 0 arrived without sync: framing lost
                        sync_err_d = 1'b1;
                        sel_d      = 3'd0;
                        state_d    = ST_HUNT;
                    end else if (sel_q == 3'd7) begin
                        // Last slot goes straight to dout along with the shadow
                        dout_d        = {din, shadow_q[7*DATA_W-1:0]};
                        frame_valid_d = 1'b1;
                        sel_d         = 3'd0;
                    end else begin
                        shadow_d[sel_q*DATA_W +: DATA_W] = din;
                        sel_d                            = sel_q + 3'd1;
                    end
                end

                default: begin
                    state_d = ST_HUNT;
                    sel_d   = 3'd0;
                end
            endcase
        end else begin
            // Idle cycle: only the pulses fall back to zero
            state_d = state_q;
        end
    end

    // Framing state, slot counter and the two status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HUNT;
            sel_q         <= 3'd0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    // Shadow collection register and published frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= {FRAME_W{1'b0}};
            dout_q   <= {FRAME_W{1'b0}};
        end else begin
            shadow_q <= shadow_d;
            dout_q   <= dout_d;
        end
    end

    assign dout        = dout_q;
    assign frame_valid = frame_valid_q;
    assign sel         = sel_q;
    assign locked      = (state_q == ST_RECV);
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1to8.sv
// Self-checking bench for tdm_demux_1to8 (DATA_W = 1).
// The reference model keeps the beats of the frame in progress in a queue:
// the queue length is the expected slot index and eight entries make a frame.

module tb_tdm_demux_1to8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [0:0] din = 1'b0;
    logic       din_valid = 1'b0;
    logic       frame_sync = 1'b0;
    logic [7:0] dout;
    logic       frame_valid;
    logic [2:0] sel;
    logic       locked;
    logic       sync_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic       m_locked = 1'b0;
    logic       m_frame[$];
    logic [7:0] m_dout = 8'h00;
    logic       m_fv = 1'b0;
    logic       m_err = 1'b0;
    int         fv_count = 0;
    int         err_count = 0;

    tdm_demux_1to8 #(.DATA_W(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .dout        (dout),
        .frame_valid (frame_valid),
        .sel         (sel),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_frame.delete();
        m_dout = 8'h00;
        m_fv   = 1'b0;
        m_err  = 1'b0;
    endtask

    // Behaviour of one clock edge, described in frame/queue terms
    task automatic model_edge(input logic v, input logic s, input logic d);
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_frame.delete();
                    m_frame.push_back(d);
                    m_locked = 1'b1;
                end
            end else if (s) begin
                m_err = (m_frame.size() != 0);
                m_frame.delete();
                m_frame.push_back(d);
            end else if (m_frame.size() == 0) begin
                m_err    = 1'b1;
                m_locked = 1'b0;
            end else begin
                m_frame.push_back(d);
                if (m_frame.size() == 8) begin
                    for (int k = 0; k < 8; k++) m_dout[k] = m_frame[k];
                    m_frame.delete();
                    m_fv = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("dout",        32'(dout),        32'(m_dout));
        chk("frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("sync_err",    32'(sync_err),    32'(m_err));
        chk("locked",      32'(locked),      32'(m_locked));
        chk("sel",         32'(sel),         32'(m_locked ? m_frame.size() : 0));
    endtask

    // Drive one cycle, advance the model, then sample just after the edge
    task automatic step(input logic v, input logic s, input logic d);
        @(negedge clk);
        din_valid  = v;
        frame_sync = s;
        din        = d;
        model_edge(v, s, d);
        @(posedge clk);
        #1;
        if (frame_valid) fv_count++;
        if (sync_err) err_count++;
        check_all();
    endtask

    task automatic frame(input logic [7:0] bits, input logic with_sync);
        for (int k = 0; k < 8; k++) step(1'b1, (k == 0) && with_sync, bits[k]);
    endtask

    initial begin
        // Reset state
        #12;
        chk("reset_dout", 32'(dout), 32'h0);
        chk("reset_sel",  32'(sel), 32'h0);
        chk("reset_locked", 32'(locked), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: single frame 0,1,0,1,1,0,1,0 for slots 0..7
        fv_count = 0;
        frame(8'b0101_1010, 1'b1);
        chk("t1_dout", 32'(dout), 32'h5A);
        chk("t1_fv_count", 32'(fv_count), 32'd1);
        chk("t1_locked", 32'(locked), 32'd1);

        // Test 2: back-to-back frames, second frame 1,1,1,1,0,0,0,0
        fv_count = 0; err_count = 0;
        frame(8'b1010_0101, 1'b1);
        frame(8'b0000_1111, 1'b1);
        chk("t2_dout", 32'(dout), 32'h0F);
        chk("t2_fv_count", 32'(fv_count), 32'd2);
        chk("t2_err_count", 32'(err_count), 32'd0);

        // Test 3: three idle cycles between slots 3 and 4
        fv_count = 0;
        for (int k = 0; k < 4; k++) step(1'b1, k == 0, k[0]);
        for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'b0, 1'b1);
            chk("t3_gap_sel", 32'(sel), 32'd4);
        end
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("t3_dout", 32'(dout), 32'h5A);
        chk("t3_fv_count", 32'(fv_count), 32'd1);

        // Test 5: missing sync on slot 0 drops lock, dout keeps last frame
        err_count = 0;
        step(1'b1, 1'b0, 1'b1);
        chk("t5_err_count", 32'(err_count), 32'd1);
        chk("t5_locked", 32'(locked), 32'd0);
        chk("t5_dout", 32'(dout), 32'h5A);

        // Test 4: beats without sync in HUNT, then early sync at slot 5
        err_count = 0; fv_count = 0;
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b1);
        chk("t4_hunt_sel", 32'(sel), 32'd0);
        chk("t4_hunt_err", 32'(err_count), 32'd0);
        for (int k = 0; k < 5; k++) step(1'b1, k == 0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk("t4_early_err", 32'(err_count), 32'd1);
        chk("t4_early_sel", 32'(sel), 32'd1);
        chk("t4_no_fv", 32'(fv_count), 32'd0);
        for (int k = 1; k < 8; k++) step(1'b1, 1'b0, k >= 4);
        chk("t4_dout", 32'(dout), 32'hF0);

        // Test 6: asynchronous reset between edges, mid-frame after slot 4
        for (int k = 0; k < 5; k++) step(1'b1, k == 0, 1'b1);
        #2;
        rst_n = 1'b0;
        din_valid = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_dout", 32'(dout), 32'h0);
        chk("t6_rst_sel", 32'(sel), 32'h0);
        chk("t6_rst_locked", 32'(locked), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        frame(8'hFF, 1'b1);
        chk("t6_dout", 32'(dout), 32'hFF);

        // Randomized traffic with gaps, good syncs and occasional violations
        for (int i = 0; i < 600; i++) begin
            logic v, s, d;
            v = ($urandom_range(0, 9) < 8);
            d = 1'($urandom);
            if (!m_locked || m_frame.size() == 0)
                s = ($urandom_range(0, 9) < 9);
            else
                s = ($urandom_range(0, 29) == 0);
            step(v, s, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
